syn_anti_alias_job_que: RTL and testbench

Job queue in front of the grapheme anti-alias engine. Accepts pixel jobs pushed by the line rasteriser, buffers them in a parameterised FIFO, presents them to the anti-alias engine over a valid/ready handshake, and generates the `job_que_empty` status plus overflow and high-water-mark status for local bus (LB) readback.

---
 rtl/syn_gpu_pkg.sv | 21 ++
 rtl/syn_sdp_ram.sv | 33 +++
 rtl/syn_anti_alias_job_que.sv | 164 ++++++++++++++++
 tb/tb_syn_anti_alias_job_que.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/syn_gpu_pkg.sv
// Shared GPU types: default job field widths, the job record and the
// occupancy-width helper used by queue status counters.
package syn_gpu_pkg;

  localparam int C_X_W   = 10;
  localparam int C_Y_W   = 9;
  localparam int C_PXL_W = 8;
  localparam int C_DEPTH = 16;

  typedef struct packed {
    logic [C_X_W-1:0]   x;
    logic [C_Y_W-1:0]   y;
    logic [C_PXL_W-1:0] pxl;
  } aa_job_t;

  // Occupancy needs one extra bit so that "completely full" is representable.
  function automatic int occ_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/syn_sdp_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Read-during-write to the same address returns the old contents; callers
// that need the new word must forward it themselves.
module syn_sdp_ram
  import syn_gpu_pkg::*;
#(
  parameter int P_W     = $bits(aa_job_t),
  parameter int P_DEPTH = C_DEPTH,
  parameter int P_AW    = $clog2(P_DEPTH)
) (
  input  logic            clk_ir,
  input  logic            wr_en,
  input  logic [P_AW-1:0] wr_addr,
  input  logic [P_W-1:0]  wr_data,
  input  logic [P_AW-1:0] rd_addr,
  output logic [P_W-1:0]  rd_data
);

  logic [P_W-1:0] mem [P_DEPTH];

  // Write port.
  always_ff @(posedge clk_ir) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read port, always enabled.
  always_ff @(posedge clk_ir) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/syn_anti_alias_job_que.sv
// Job queue between the line rasteriser and the anti-alias engine.
// A RAM holds the body of the queue; the head job lives in an output
// register so the engine sees registered data and can pop once per cycle.
module syn_anti_alias_job_que
  import syn_gpu_pkg::*;
#(
  parameter int P_X_W   = C_X_W,
  parameter int P_Y_W   = C_Y_W,
  parameter int P_PXL_W = C_PXL_W,
  parameter int P_DEPTH = C_DEPTH
) (
  input  logic                        clk_ir,
  input  logic                        rst_il,
  input  logic                        push_i,
  input  logic [P_X_W-1:0]            push_x_i,
  input  logic [P_Y_W-1:0]            push_y_i,
  input  logic [P_PXL_W-1:0]          push_pxl_i,
  output logic                        job_que_full_o,
  output logic                        aa_valid_o,
  input  logic                        aa_ready_i,
  output logic [P_X_W-1:0]            aa_x_o,
  output logic [P_Y_W-1:0]            aa_y_o,
  output logic [P_PXL_W-1:0]          aa_pxl_o,
  output logic                        job_que_empty_o,
  output logic [occ_w(P_DEPTH)-1:0]   occ_o,
  output logic [occ_w(P_DEPTH)-1:0]   hwm_o,
  output logic                        ovrflw_o,
  input  logic                        lb_clr_i
);

  localparam int AW = $clog2(P_DEPTH);
  localparam int OW = occ_w(P_DEPTH);

  typedef struct packed {
    logic [P_X_W-1:0]   x;
    logic [P_Y_W-1:0]   y;
    logic [P_PXL_W-1:0] pxl;
  } job_t;

  job_t          push_job;
  job_t          ram_q;
  job_t          head_job;
  job_t          fwd_job_reg;
  job_t          out_job_reg;
  logic          fwd_valid_reg;
  logic          out_valid_reg;
  logic          full_reg;
  logic          empty_reg;
  logic          ovrflw_reg;
  logic [AW-1:0] wptr_reg;
  logic [AW-1:0] rptr_reg;
  logic [AW-1:0] rptr_next;
  logic [OW-1:0] occ_reg;
  logic [OW-1:0] occ_next;
  logic [OW-1:0] hwm_reg;
  logic          push_ok;
  logic          pop;
  logic          ram_empty;
  logic          bypass;
  logic          ram_wr;
  logic          ram_rd;

  assign push_job = {push_x_i, push_y_i, push_pxl_i};

  // Handshake decode, RAM steering and next-state occupancy.
  always_comb begin
    push_ok   = push_i & ~full_reg;
    pop       = out_valid_reg & aa_ready_i;
    // The output register holds one job, so the RAM never holds more than
    // P_DEPTH-1 and equal pointers always mean "RAM empty".
    ram_empty = (wptr_reg == rptr_reg);
    bypass    = push_ok & (~out_valid_reg | (pop & ram_empty));
    ram_wr    = push_ok & ~bypass;
    ram_rd    = pop & ~ram_empty;
    rptr_next = ram_rd ? rptr_reg + AW'(1) : rptr_reg;
    occ_next  = occ_reg + OW'(push_ok) - OW'(pop);
    // A word written on the edge it was being prefetched reads back stale
    // from the RAM; substitute the captured copy instead.
    head_job  = fwd_valid_reg ? fwd_job_reg : ram_q;
  end

  syn_sdp_ram #(
    .P_W     ($bits(job_t)),
    .P_DEPTH (P_DEPTH),
    .P_AW    (AW)
  ) u_ram (
    .clk_ir  (clk_ir),
    .wr_en   (ram_wr),
    .wr_addr (wptr_reg),
    .wr_data (push_job),
    .rd_addr (rptr_next),
    .rd_data (ram_q)
  );

  // Pointers and write-to-prefetch forwarding.
  always_ff @(posedge clk_ir) begin
    if (rst_il) begin
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      fwd_valid_reg <= 1'b0;
      fwd_job_reg   <= '0;
    end else begin
      if (ram_wr) begin
        wptr_reg <= wptr_reg + AW'(1);
      end
      rptr_reg      <= rptr_next;
      fwd_valid_reg <= ram_wr && (wptr_reg == rptr_next);
      fwd_job_reg   <= push_job;
    end
  end

  // Head-of-queue output register: bypass load, reload on pop, or empty.
  always_ff @(posedge clk_ir) begin
    if (rst_il) begin
      out_valid_reg <= 1'b0;
      out_job_reg   <= '0;
    end else if (bypass) begin
      out_valid_reg <= 1'b1;
      out_job_reg   <= push_job;
    end else if (pop) begin
      out_valid_reg <= ~ram_empty;
      if (!ram_empty) begin
        out_job_reg <= head_job;
      end
    end
  end

  // Occupancy, registered full/empty flags, high-water mark and overflow.
  always_ff @(posedge clk_ir) begin
    if (rst_il) begin
      occ_reg    <= '0;
      full_reg   <= 1'b0;
      empty_reg  <= 1'b1;
      hwm_reg    <= '0;
      ovrflw_reg <= 1'b0;
    end else begin
      occ_reg   <= occ_next;
      full_reg  <= (occ_next == OW'(P_DEPTH));
      empty_reg <= (occ_next == '0);
      if (lb_clr_i) begin
        hwm_reg <= occ_next;
      end else if (occ_next > hwm_reg) begin
        hwm_reg <= occ_next;
      end
      // A dropped push outranks a coincident clear.
      if (push_i && full_reg) begin
        ovrflw_reg <= 1'b1;
      end else if (lb_clr_i) begin
        ovrflw_reg <= 1'b0;
      end
    end
  end

  assign aa_valid_o      = out_valid_reg;
  assign aa_x_o          = out_job_reg.x;
  assign aa_y_o          = out_job_reg.y;
  assign aa_pxl_o        = out_job_reg.pxl;
  assign occ_o           = occ_reg;
  assign hwm_o           = hwm_reg;
  assign ovrflw_o        = ovrflw_reg;
  assign job_que_full_o  = full_reg;
  assign job_que_empty_o = empty_reg;

endmodule

// File: tb/tb_syn_anti_alias_job_que.sv
// Directed bench for the anti-alias job queue: a queue-based reference model
// checked on every cycle plus hand-computed expectations per scenario.
module tb_syn_anti_alias_job_que;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       push;
  logic [9:0] push_x;
  logic [8:0] push_y;
  logic [7:0] push_pxl;
  logic       full;
  logic       aa_valid;
  logic       aa_ready;
  logic [9:0] aa_x;
  logic [8:0] aa_y;
  logic [7:0] aa_pxl;
  logic       empty;
  logic [4:0] occ;
  logic [4:0] hwm;
  logic       ovrflw;
  logic       lb_clr;

  int checks = 0;
  int errors = 0;
  int jid    = 1;

  always #5 clk = ~clk;

  syn_anti_alias_job_que dut (
    .clk_ir          (clk),
    .rst_il          (rst),
    .push_i          (push),
    .push_x_i        (push_x),
    .push_y_i        (push_y),
    .push_pxl_i      (push_pxl),
    .job_que_full_o  (full),
    .aa_valid_o      (aa_valid),
    .aa_ready_i      (aa_ready),
    .aa_x_o          (aa_x),
    .aa_y_o          (aa_y),
    .aa_pxl_o        (aa_pxl),
    .job_que_empty_o (empty),
    .occ_o           (occ),
    .hwm_o           (hwm),
    .ovrflw_o        (ovrflw),
    .lb_clr_i        (lb_clr)
  );

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: a plain job queue updated with the accepted transfers.
  logic [26:0] mq[$];
  int          m_hwm = 0;
  bit          m_ovf = 0;
  bit          started = 0;
  bit          was_full;
  logic [26:0] popped;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_hwm   = 0;
      m_ovf   = 0;
      started = 1;
    end else if (started) begin
      was_full = (mq.size() == DEPTH);
      if (aa_ready && mq.size() > 0) begin
        popped = mq.pop_front();
        $display("pop  x=%0d y=%0d pxl=%0h", popped[26:17], popped[16:8], popped[7:0]);
      end
      if (push && !was_full) begin
        mq.push_back({push_x, push_y, push_pxl});
        $display("push x=%0d y=%0d pxl=%0h", push_x, push_y, push_pxl);
      end else if (push) begin
        $display("drop x=%0d y=%0d pxl=%0h", push_x, push_y, push_pxl);
      end
      if (push && was_full) m_ovf = 1;
      else if (lb_clr) m_ovf = 0;
      if (lb_clr) m_hwm = mq.size();
      else if (mq.size() > m_hwm) m_hwm = mq.size();
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (started) begin
      check("m_valid", aa_valid, int'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("m_x", aa_x, int'(mq[0][26:17]));
        check("m_y", aa_y, int'(mq[0][16:8]));
        check("m_pxl", aa_pxl, int'(mq[0][7:0]));
      end
      check("m_occ", occ, mq.size());
      check("m_full", full, int'(mq.size() == DEPTH));
      check("m_empty", empty, int'(mq.size() == 0));
      check("m_hwm", hwm, m_hwm);
      check("m_ovf", ovrflw, int'(m_ovf));
    end
  end

  // Apply one cycle of stimulus at the falling edge, return at the next one.
  task automatic drive_job(input logic p, input logic [9:0] x, input logic [8:0] y,
                           input logic [7:0] px, input logic r, input logic c);
    push     = p;
    push_x   = x;
    push_y   = y;
    push_pxl = px;
    aa_ready = r;
    lb_clr   = c;
    @(negedge clk);
  endtask

  task automatic drive(input logic p, input logic r, input logic c);
    drive_job(p, 10'(jid), 9'(jid * 3), 8'(jid ^ 8'h5A), r, c);
    if (p) jid++;
  endtask

  initial begin
    int first;
    rst = 1'b1; push = 0; push_x = '0; push_y = '0; push_pxl = '0;
    aa_ready = 0; lb_clr = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_valid", aa_valid, 0);
    check("rst_empty", empty, 1);
    check("rst_occ", occ, 0);

    // 1: single job through the bypass path.
    drive_job(1, 10'd5, 9'd7, 8'hA0, 0, 0);
    check("t1_valid", aa_valid, 1);
    check("t1_x", aa_x, 5);
    check("t1_y", aa_y, 7);
    check("t1_pxl", aa_pxl, 'hA0);
    check("t1_occ", occ, 1);
    check("t1_empty", empty, 0);
    drive(0, 1, 0);
    check("t1_pop_valid", aa_valid, 0);
    check("t1_pop_empty", empty, 1);

    // 2: fill, overflow, drain.
    first = jid;
    for (int i = 0; i < 16; i++) drive(1, 0, 0);
    check("t2_full", full, 1);
    check("t2_occ", occ, 16);
    check("t2_head", aa_x, first);
    drive(1, 0, 0);
    check("t2_ovf", ovrflw, 1);
    check("t2_occ_hold", occ, 16);
    for (int i = 0; i < 16; i++) drive(0, 1, 0);
    check("t2_drained", aa_valid, 0);
    check("t2_drain_empty", empty, 1);

    // 3: streaming, one job per cycle.
    drive(0, 0, 1);
    check("t3_clr_ovf", ovrflw, 0);
    for (int i = 0; i < 100; i++) begin
      drive(1, 1, 0);
      check("t3_occ_le1", int'(occ <= 1), 1);
    end
    check("t3_no_ovf", ovrflw, 0);
    drive(0, 1, 0);

    // 4: simultaneous push/pop at 8 and at full.
    for (int i = 0; i < 8; i++) drive(1, 0, 0);
    drive(1, 1, 0);
    check("t4_occ8", occ, 8);
    for (int i = 0; i < 8; i++) drive(1, 0, 0);
    check("t4_full", full, 1);
    drive(1, 1, 0);
    check("t4_occ15", occ, 15);
    check("t4_ovf", ovrflw, 1);
    for (int i = 0; i < 15; i++) drive(0, 1, 0);

    // 5: high-water mark and LB clear.
    drive(0, 0, 1);
    check("t5_clr_hwm", hwm, 0);
    for (int i = 0; i < 12; i++) drive(1, 0, 0);
    for (int i = 0; i < 9; i++) drive(0, 1, 0);
    check("t5_hwm12", hwm, 12);
    check("t5_occ3", occ, 3);
    drive(0, 0, 1);
    check("t5_hwm3", hwm, 3);
    check("t5_ovf0", ovrflw, 0);
    for (int i = 0; i < 13; i++) drive(1, 0, 0);
    drive(1, 0, 1);
    check("t5_set_wins", ovrflw, 1);
    check("t5_hwm16", hwm, 16);

    // 6: reset with 10 jobs queued.
    for (int i = 0; i < 6; i++) drive(0, 1, 0);
    check("t6_occ10", occ, 10);
    rst = 1'b1;
    drive(0, 0, 0);
    rst = 1'b0;
    check("t6_valid", aa_valid, 0);
    check("t6_x", aa_x, 0);
    check("t6_occ", occ, 0);
    check("t6_hwm", hwm, 0);
    check("t6_ovf", ovrflw, 0);
    check("t6_empty", empty, 1);
    check("t6_full", full, 0);
    first = jid;
    drive(1, 0, 0);
    check("t6_first_x", aa_x, first);
    check("t6_first_valid", aa_valid, 1);
    drive(0, 1, 0);
    check("t6_done", aa_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
